// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and helpers for the fetch PC generator.
//   pc_src_e : which source produced the next PC (reported on pc_src)
//   pend_e   : kind of redirect latched while the pipeline is stalled; the
//              numeric order is also the capture priority (higher wins)
//   align_word() : clears bits[1:0] of an address (word alignment)
// -----------------------------------------------------------------------------
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_RET    = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_BRANCH = 3'd3,
    SRC_PEND   = 3'd4,
    SRC_EXC    = 3'd5,
    SRC_HOLD   = 3'd6
  } pc_src_e;

  typedef enum logic [1:0] {
    PEND_NONE   = 2'd0,
    PEND_JUMP   = 2'd1,
    PEND_BRANCH = 2'd2,
    PEND_EXC    = 2'd3
  } pend_e;

  // Widest address the helper handles; callers cast in and out of this width
  // so the helper stays independent of the ADDR_W parameter.
  localparam int unsigned MAX_ADDR_W = 64;

  function automatic logic [MAX_ADDR_W-1:0] align_word(input logic [MAX_ADDR_W-1:0] addr);
    return {addr[MAX_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
// Bundles the control/target inputs and the PC/status outputs of pc_gen.
//   master : hazard unit / EX resolution / decode side (drives requests)
//   slave  : pc_gen
//
// Signalling: every request (stall, exc, branch, jump, ret, call) is a
// level sampled once per rising clock edge; there is no ready/back-pressure
// path. A request is consumed at the edge where it is high. Targets are only
// meaningful in the cycle their strobe is high. Outputs pc, redirect_pending,
// ras_empty, ras_full and pend_type are registered state; pc_plus4 and pc_src
// are combinational views of the current cycle.
// -----------------------------------------------------------------------------
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic              stall;
  logic              exc;
  logic              branch;
  logic [ADDR_W-1:0] branch_pc;
  logic              jump;
  logic [ADDR_W-1:0] jump_pc;
  logic              ret;
  logic              call;
  logic [ADDR_W-1:0] link_addr;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect_pending;
  logic              ras_empty;
  logic              ras_full;
  pc_src_e           pc_src;
  pend_e             pend_type;   // debug view of the pending-redirect state

  modport master (
    output stall, exc, branch, branch_pc, jump, jump_pc, ret, call, link_addr,
    input  pc, pc_plus4, redirect_pending, ras_empty, ras_full, pc_src, pend_type
  );

  modport slave (
    input  stall, exc, branch, branch_pc, jump, jump_pc, ret, call, link_addr,
    output pc, pc_plus4, redirect_pending, ras_empty, ras_full, pc_src, pend_type
  );

endinterface

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Circular return-address stack.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write data_i on top (count saturates at RAS_DEPTH; the
//                 oldest entry is overwritten when full)
//   pop_i       : drop the top entry (ignored when empty)
//   data_i      : address to push
//   top_o       : current top entry (valid when !empty_o)
//   empty_o     : count == 0
//   full_o      : count == RAS_DEPTH
//   count_o     : number of valid entries
// push_i and pop_i together replace the top in place; count is unchanged.
// RAS_DEPTH must be a power of two so the pointer wraps naturally.
// -----------------------------------------------------------------------------
module pc_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [ADDR_W-1:0]            data_i,
  output logic [ADDR_W-1:0]            top_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;     // next free slot
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic              wr_en;
  logic              pop_ok;

  assign top_idx = ptr_q - PTR_W'(1);
  assign pop_ok  = pop_i && (count_q != '0);

  assign top_o   = mem_q[top_idx];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(RAS_DEPTH));
  assign count_o = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (push_i && pop_ok) begin
      // Replace the top in place: net effect of pop followed by push.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop_ok) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (wr_en) begin
        mem_q[wr_idx] <= data_i;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Fetch PC register and next-PC selection for the 5-stage MIPS pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_gen_if.slave
//     inputs  stall, exc, branch/branch_pc, jump/jump_pc, ret, call/link_addr
//     outputs pc (registered), pc_plus4, redirect_pending, ras_empty,
//             ras_full, pc_src, pend_type (pending-redirect state)
// Next-PC priority when not stalled:
//   exc > pending > branch > jump > ret (RAS non-empty) > pc+4
// While stalled the PC holds and exc/branch/jump are captured into a single
// pending slot so the redirect survives until the stall is released.
// -----------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] EXC_VEC_A  = {EXC_VEC[ADDR_W-1:2], 2'b00};

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return ADDR_W'(align_word(MAX_ADDR_W'(a)));
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  pend_e             pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  pc_src_e           src;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_tgt, jmp_tgt, link_tgt;
  pend_e             req_type;
  logic [ADDR_W-1:0] req_pc;

  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign br_tgt   = align(bus.branch_pc);
  assign jmp_tgt  = align(bus.jump_pc);
  assign link_tgt = align(bus.link_addr);

  // Highest-priority redirect requested this cycle, used for stall capture.
  always_comb begin
    req_type = PEND_NONE;
    req_pc   = '0;
    if (bus.exc) begin
      req_type = PEND_EXC;
      req_pc   = EXC_VEC_A;
    end else if (bus.branch) begin
      req_type = PEND_BRANCH;
      req_pc   = br_tgt;
    end else if (bus.jump) begin
      req_type = PEND_JUMP;
      req_pc   = jmp_tgt;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    src       = SRC_HOLD;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    if (bus.stall) begin
      // Older instruction keeps the slot unless a strictly higher-priority
      // redirect arrives; exc always re-captures.
      if ((req_type == PEND_EXC) || (req_type > pend_q)) begin
        pend_d    = req_type;
        pend_pc_d = req_pc;
      end
    end else begin
      pend_d   = PEND_NONE;
      // RAS tracks call/ret regardless of which source wins the PC select.
      ras_push = bus.call;
      ras_pop  = bus.ret && !ras_empty;
      if (bus.exc) begin
        pc_d = EXC_VEC_A;
        src  = SRC_EXC;
      end else if (pend_q != PEND_NONE) begin
        pc_d = pend_pc_q;
        src  = SRC_PEND;
      end else if (bus.branch) begin
        pc_d = br_tgt;
        src  = SRC_BRANCH;
      end else if (bus.jump) begin
        pc_d = jmp_tgt;
        src  = SRC_JUMP;
      end else if (bus.ret && !ras_empty) begin
        pc_d = ras_top;
        src  = SRC_RET;
      end else begin
        pc_d = pc_plus4;
        src  = SRC_SEQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC_A;
      pend_q    <= PEND_NONE;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (link_tgt),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full),
    .count_o (ras_count)
  );

  assign bus.pc               = pc_q;
  assign bus.pc_plus4         = pc_plus4;
  assign bus.redirect_pending = (pend_q != PEND_NONE);
  assign bus.ras_empty        = ras_empty;
  assign bus.ras_full         = ras_full;
  assign bus.pc_src           = src;
  assign bus.pend_type        = pend_q;

  logic unused_ok;
  assign unused_ok = ^ras_count;

endmodule
